sfi_pair_builder: RTL and testbench
===================================

# sfi_pair_builder

Streaming front end for the SFI rewrite stage. It accepts one 32-bit MIPS instruction per handshake and forms a sliding 64-bit window {previous instruction, current instruction}, so the SFI stage always sees each store together with the instruction slot that precedes it. Windows are queued in a small FIFO with a valid/ready output. Each window is tagged when its current instruction is a store.

## Interface
- DEPTH, 4: output FIFO depth in pairs; power of two, ≥2
- NOP, 32'h00000000: filler used as the previous instruction after reset and after a program end
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_instr valid
- in_ready  out  1  block can accept an instruction this cycle
- in_instr  in  32  instruction word
- in_last  in  1  qualifies in_instr as the final instruction of a program
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer (SFI stage) accepts the head
- out_pair  out  64  {prev[31:0], curr[31:0]}; directly forms the SFI stage's 64-bit input
- out_store  out  1  curr opcode is a store
- pair_cnt  out  16  pairs pushed since reset, wraps
- store_cnt  out  16  store-tagged pairs pushed since reset, wraps

## Operation
- Store opcodes (bits 31:26): 0x28 SB, 0x29 SH, 0x2A SWL, 0x2B SW, 0x2C SDL, 0x2D SDR, 0x2E SWR, 0x38 SC, 0x3C SCD, 0x3F SD. Every other opcode is a non-store.
- prev register:
  - Holds the last accepted instruction.
  - Reset value is NOP.
- Accept condition: in_valid && in_ready. On accept:
  - Push {prev, in_instr} with out_store = is_store(in_instr).
  - prev <= in_last ? NOP : in_instr.
  - pair_cnt increments by 1.
  - store_cnt increments by 1 if the word is a store.
- Pop condition: out_valid && out_ready. The head advances.
- FIFO:
  - Circular buffer with rd_ptr, wr_ptr and occupancy count (0..DEPTH).
  - Pointers wrap modulo DEPTH.
- in_ready = (count != DEPTH). This is independent of out_ready, and there is no bypass when full.
- Simultaneous push and pop:
  - Allowed whenever count is in 1..DEPTH-1.
  - count is unchanged.
  - Both pointers advance.
- Empty FIFO: out_valid=0, out_pair=0, out_store=0.
- in_valid while in_ready=0: the word is not consumed and prev is unchanged. The upstream holds in_instr and in_last stable until accepted.
- out_pair and out_store remain stable while out_valid=1 and out_ready=0.
- Counters wrap 16'hFFFF -> 16'h0000 with no saturation.

## Timing
- Reset values (on rising clk with rst=1):
  - in_ready=1
  - out_valid=0, out_pair=0, out_store=0
  - pair_cnt=0, store_cnt=0
  - FIFO empty; prev=NOP
- Reset asserted mid-stream discards all queued pairs and prev. An in_valid in the reset cycle is ignored.
- Latency:
  - A word accepted in cycle N appears as the head in cycle N+1 if the FIFO was empty.
  - There is no combinational path from in_* to out_*.
- Throughput is 1 pair/cycle when out_ready is held high.
- in_ready depends only on registered count, with no combinational path from out_ready.
- Counters update in the same edge as the push.

## Test plan
- Reset, then push 0xA0111111 (SB), then 0x00432820 -> pair 1 = 64'h00000000A0111111 with store=1; pair 2 = 64'hA011111100432820 with store=0; pair_cnt=2, store_cnt=1.
- in_last: push 0x20210001 with in_last=1, then 0xAC111111 -> second pair = 64'h00000000AC111111 with store=1, which confirms prev was reset to NOP.
- Backpressure: hold out_ready=0 and stream 6 words with DEPTH=4 -> in_ready drops after the 4th accept; words 5–6 wait. Release out_ready -> all 6 pairs emerge in order with no loss or duplication, and out_pair is stable while stalled.
- Opcode sweep: push one word for each of the 10 store opcodes plus 0x08, 0x23 (LW) and 0x00 -> out_store=1 exactly for the 10 store opcodes; store_cnt=10.
- Full-rate push/pop with out_ready=1: stream 1000 words -> count stays ≤1, in_ready stays 1, pair_cnt=1000, and each pair equals {word[i-1], word[i]}.
- Mid-stream rst with 3 queued pairs -> next cycle out_valid=0, both counters 0; the next pushed word pairs with NOP. A separate case forces 65537 pushes -> pair_cnt=1.

Source files
------------

// File: rtl/sfi_pair_builder.sv
// Sliding {prev, curr} instruction-pair builder for the SFI rewrite stage.
// Pairs are queued in a small circular FIFO and tagged when curr is a store.
module sfi_pair_builder #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pair,
  output logic        out_store,
  output logic [15:0] pair_cnt,
  output logic [15:0] store_cnt
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  function automatic logic is_store(input logic [31:0] instr);
    case (instr[31:26])
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C,
      6'h2D, 6'h2E, 6'h38, 6'h3C, 6'h3F: is_store = 1'b1;
      default:                           is_store = 1'b0;
    endcase
  endfunction

  // Each entry is {store tag, prev, curr}.
  logic [64:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [31:0]   prev;
  logic          push;
  logic          pop;
  logic          curr_store;

  // in_ready comes from the registered count only, so out_ready never reaches it.
  assign in_ready   = (count != FULL);
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign curr_store = is_store(in_instr);
  assign out_pair   = out_valid ? mem[rd_ptr][63:0] : 64'h0;
  assign out_store  = out_valid && mem[rd_ptr][64];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {curr_store, prev, in_instr};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      prev      <= NOP;
      pair_cnt  <= 16'h0000;
      store_cnt <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        prev     <= in_last ? NOP : in_instr;
        pair_cnt <= pair_cnt + 16'h0001;
        if (curr_store) begin
          store_cnt <= store_cnt + 16'h0001;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sfi_pair_builder.sv
// Self-checking bench for sfi_pair_builder: directed table, corner sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_sfi_pair_builder;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pair;
  logic        out_store;
  logic [15:0] pair_cnt;
  logic [15:0] store_cnt;

  sfi_pair_builder #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_pair(out_pair), .out_store(out_store),
    .pair_cnt(pair_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of {store, prev, curr} entries plus prev and counters.
  logic [64:0] mq[$];
  logic [31:0] m_prev = NOP;
  logic [15:0] m_pcnt = 16'h0;
  logic [15:0] m_scnt = 16'h0;
  logic        last_push;
  logic [63:0] recv[$];

  function automatic logic ref_store(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return op inside {6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h38, 6'h3C, 6'h3F};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, decide push/pop from the model, advance, update the model.
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic last,
                               input logic ordy, input logic r);
    logic push, pop;
    rst = r; in_valid = v; in_instr = instr; in_last = last; out_ready = ordy;
    push = !r && v && (mq.size() < DEPTH);
    pop  = !r && (mq.size() > 0) && ordy;
    if (out_valid && out_ready) recv.push_back(out_pair);
    @(posedge clk); #1;
    last_push = push;
    if (r) begin
      mq.delete(); m_prev = NOP; m_pcnt = 16'h0; m_scnt = 16'h0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back({ref_store(instr), m_prev, instr});
        m_prev = last ? NOP : instr;
        m_pcnt = m_pcnt + 16'h1;
        if (ref_store(instr)) m_scnt = m_scnt + 16'h1;
      end
    end
  endtask

  task automatic checkModel(input string tag);
    logic [64:0] head;
    head = (mq.size() > 0) ? mq[0] : 65'h0;
    checkOutput({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() != DEPTH));
    checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    checkOutput({tag, ".out_pair"},  out_pair,       head[63:0]);
    checkOutput({tag, ".out_store"}, 64'(out_store), 64'(head[64]));
    checkOutput({tag, ".pair_cnt"},  64'(pair_cnt),  64'(m_pcnt));
    checkOutput({tag, ".store_cnt"}, 64'(store_cnt), 64'(m_scnt));
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic        last;
    logic        ordy;
    logic        exp_valid;
    logic [63:0] exp_pair;
    logic        exp_store;
    logic [15:0] exp_pcnt;
    logic [15:0] exp_scnt;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] words[6];
  logic [5:0]  ops[13];
  logic [31:0] w;
  logic [31:0] prev_w;
  int idx;
  int cyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_last = 1'b0; out_ready = 1'b0;

    vecs[0] = '{1, 32'hA0111111, 0, 1, 1, 64'h00000000_A0111111, 1, 16'd1, 16'd1};
    vecs[1] = '{1, 32'h00432820, 0, 1, 1, 64'hA0111111_00432820, 0, 16'd2, 16'd1};
    vecs[2] = '{1, 32'h20210001, 1, 1, 1, 64'h00432820_20210001, 0, 16'd3, 16'd1};
    vecs[3] = '{1, 32'hAC111111, 0, 1, 1, 64'h00000000_AC111111, 1, 16'd4, 16'd2};
    vecs[4] = '{0, 32'h00000000, 0, 1, 0, 64'h0,                 0, 16'd4, 16'd2};
    vecs[5] = '{1, 32'hE0000005, 0, 1, 1, 64'hAC111111_E0000005, 1, 16'd5, 16'd3};
    vecs[6] = '{1, 32'h8C000000, 0, 0, 1, 64'hAC111111_E0000005, 1, 16'd6, 16'd3};
    vecs[7] = '{0, 32'h00000000, 0, 0, 1, 64'hAC111111_E0000005, 1, 16'd6, 16'd3};
    vecs[8] = '{0, 32'h00000000, 0, 1, 1, 64'hE0000005_8C000000, 0, 16'd6, 16'd3};
    vecs[9] = '{0, 32'h00000000, 0, 1, 0, 64'h0,                 0, 16'd6, 16'd3};

    // Reset values, including an in_valid during reset that must be ignored.
    applyStimulus(1'b1, 32'hAC000000, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'hAC000000, 1'b0, 1'b1, 1'b1);
    checkOutput("reset.in_ready",  64'(in_ready),  64'h1);
    checkOutput("reset.out_valid", 64'(out_valid), 64'h0);
    checkOutput("reset.out_pair",  out_pair,       64'h0);
    checkOutput("reset.out_store", 64'(out_store), 64'h0);
    checkOutput("reset.pair_cnt",  64'(pair_cnt),  64'h0);
    checkOutput("reset.store_cnt", 64'(store_cnt), 64'h0);

    // Directed table: pairing, in_last, stall, drain.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].v, vecs[i].instr, vecs[i].last, vecs[i].ordy, 1'b0);
      checkOutput($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d.out_pair", i),  out_pair,       vecs[i].exp_pair);
      checkOutput($sformatf("vec%0d.out_store", i), 64'(out_store), 64'(vecs[i].exp_store));
      checkOutput($sformatf("vec%0d.pair_cnt", i),  64'(pair_cnt),  64'(vecs[i].exp_pcnt));
      checkOutput($sformatf("vec%0d.store_cnt", i), 64'(store_cnt), 64'(vecs[i].exp_scnt));
      checkModel($sformatf("vec%0d", i));
    end

    // Backpressure: six words into a four-deep FIFO with the consumer stalled.
    doReset();
    for (int i = 0; i < 6; i++) words[i] = (i % 2 == 0) ? (32'hAC000000 + i) : (32'h00000020 + i);
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b1, words[idx], 1'b0, 1'b0, 1'b0);
      if (last_push) idx++;
      checkModel($sformatf("bp%0d", c));
      if (c >= 3) begin
        checkOutput($sformatf("bp%0d.in_ready_low", c), 64'(in_ready), 64'h0);
        checkOutput($sformatf("bp%0d.stall_pair", c),   out_pair,       {NOP, words[0]});
      end
    end
    recv.delete();
    cyc = 0;
    while (recv.size() < 6 && cyc < 40) begin
      applyStimulus(idx < 6, words[(idx < 6) ? idx : 5], 1'b0, 1'b1, 1'b0);
      if (last_push) idx++;
      checkModel($sformatf("bpd%0d", cyc));
      cyc++;
    end
    checkOutput("bp.drained_count", 64'(recv.size()), 64'd6);
    for (int i = 0; i < recv.size() && i < 6; i++) begin
      prev_w = (i == 0) ? NOP : words[i-1];
      checkOutput($sformatf("bp.order%0d", i), recv[i], {prev_w, words[i]});
    end

    // Opcode sweep: ten stores, then ADDI, LW and SPECIAL.
    doReset();
    ops = '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E, 6'h38, 6'h3C, 6'h3F,
            6'h08, 6'h23, 6'h00};
    for (int i = 0; i < 13; i++) begin
      w = {ops[i], 26'h0123456};
      applyStimulus(1'b1, w, 1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("op%02h.out_store", ops[i]), 64'(out_store), 64'(i < 10));
      checkModel($sformatf("op%0d", i));
    end
    checkOutput("sweep.store_cnt", 64'(store_cnt), 64'd10);
    checkOutput("sweep.pair_cnt",  64'(pair_cnt),  64'd13);

    // Full-rate streaming with the consumer always ready.
    doReset();
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, $urandom, ($urandom_range(0, 15) == 0), 1'b1, 1'b0);
      checkOutput("rate.in_ready", 64'(in_ready), 64'h1);
      checkModel("rate");
    end
    checkOutput("rate.pair_cnt", 64'(pair_cnt), 64'd1000);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 0) w[31:26] = 6'h28 + 6'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 3) != 0, w, ($urandom_range(0, 9) == 0),
                    $urandom_range(0, 2) != 0, 1'b0);
      checkModel("rand");
    end

    // Mid-stream reset with three queued pairs.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hAC000100 + i, 1'b0, 1'b0, 1'b0);
    checkModel("pre_rst");
    applyStimulus(1'b1, 32'hAC000777, 1'b0, 1'b0, 1'b1);
    checkOutput("midrst.out_valid", 64'(out_valid), 64'h0);
    checkOutput("midrst.pair_cnt",  64'(pair_cnt),  64'h0);
    checkOutput("midrst.store_cnt", 64'(store_cnt), 64'h0);
    applyStimulus(1'b1, 32'hAC000001, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst.nop_pair", out_pair, {NOP, 32'hAC000001});

    // Counter wrap: 65537 store pushes.
    doReset();
    for (int i = 0; i < 65537; i++) begin
      applyStimulus(1'b1, 32'hAC000000 | 32'(i & 16'hFFFF), 1'b0, 1'b1, 1'b0);
      if (i == 65534) checkOutput("wrap.pair_cnt_max", 64'(pair_cnt), 64'hFFFF);
    end
    checkOutput("wrap.pair_cnt",  64'(pair_cnt),  64'd1);
    checkOutput("wrap.store_cnt", 64'(store_cnt), 64'd1);
    checkModel("wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
